// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared defaults for the multi-ported register file and a helper
//           that derives the byte-lane count from a data width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_DATA_W    = 32;
    localparam int c_DEF_ADDR_W    = 6;
    localparam int c_DEF_NUM_RD    = 2;
    localparam int c_DEF_NUM_WR    = 2;
    localparam int c_DEF_NUM_BYTES = c_DEF_DATA_W / 8;

    // Number of 8-bit lanes in a register of the given width.
    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module  : regfile_rd_port
// Purpose : One combinational read port: entry select, hard-wired zero for
//           entry 0 and optional per-byte merge of same-cycle writes.
// Ports   : raddr_i  - read address
//           mem_i    - stored register contents
//           byp_en_i - forwarding allowed this cycle (low during reset)
//           we_i/waddr_i/wdata_i/wbe_i - write ports seen by the forward path
//           rdata_o  - read data
// Revision: 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int NUM_WR = c_DEF_NUM_WR,
    parameter int BYPASS = 1,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]              raddr_i,
    input  logic [DATA_W-1:0]              mem_i [DEPTH],
    input  logic                           byp_en_i,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR*ADDR_W-1:0]       waddr_i,
    input  logic [NUM_WR*DATA_W-1:0]       wdata_i,
    input  logic [NUM_WR*DATA_W/8-1:0]     wbe_i,
    output logic [DATA_W-1:0]              rdata_o
);

    localparam int c_NB = byte_lanes(DATA_W);

    logic [DATA_W-1:0] w_stored;
    logic [DATA_W-1:0] w_merged;

    assign w_stored = mem_i[raddr_i];

    generate
        if (BYPASS != 0) begin : g_bypass
            // Ports are applied in ascending order so the higher-numbered
            // port overrides a lower one on the same byte, matching the
            // write-side priority.
            always_comb begin
                w_merged = w_stored;
                if (byp_en_i) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (we_i[w] && (waddr_i[w*ADDR_W +: ADDR_W] == raddr_i)) begin
                            for (int b = 0; b < c_NB; b++) begin
                                if (wbe_i[w*c_NB + b]) begin
                                    w_merged[b*8 +: 8] = wdata_i[w*DATA_W + b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
        end else begin : g_no_bypass
            assign w_merged = w_stored;
            logic w_unused_byp;
            assign w_unused_byp = &{1'b0, byp_en_i, we_i, waddr_i, wdata_i, wbe_i};
        end
    endgenerate

    assign rdata_o = (raddr_i == '0) ? '0 : w_merged;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Purpose : Multi-ported register file with byte enables, entry 0 tied to
//           zero, optional write-to-read forwarding and a per-entry busy
//           scoreboard.
// Ports   : clk      - clock, rising edge
//           rst_s    - synchronous active-low reset
//           we/waddr/wdata/wbe - NUM_WR packed write ports (port 0 in LSBs)
//           raddr/rdata        - NUM_RD packed read ports
//           rsv_en/rsv_addr    - mark one entry busy
//           rbusy    - stored busy bit of the entry at each raddr
// Revision: 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int NUM_RD = c_DEF_NUM_RD,
    parameter int NUM_WR = c_DEF_NUM_WR,
    parameter int BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           rst_s,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR*ADDR_W-1:0]       waddr,
    input  logic [NUM_WR*DATA_W-1:0]       wdata,
    input  logic [NUM_WR*DATA_W/8-1:0]     wbe,
    input  logic [NUM_RD*ADDR_W-1:0]       raddr,
    output logic [NUM_RD*DATA_W-1:0]       rdata,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr,
    output logic [NUM_RD-1:0]              rbusy
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_NB    = byte_lanes(DATA_W);

    logic [DATA_W-1:0]  mem_q [c_DEPTH];
    logic [DATA_W-1:0]  mem_d [c_DEPTH];
    logic [c_DEPTH-1:0] busy_q;
    logic [c_DEPTH-1:0] busy_d;

    // Next state. Later assignments win, which gives port 1 byte priority
    // over port 0 and lets a reservation override a same-cycle busy clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (we[w]) begin
                busy_d[waddr[w*ADDR_W +: ADDR_W]] = 1'b0;
                for (int b = 0; b < c_NB; b++) begin
                    if (wbe[w*c_NB + b]) begin
                        mem_d[waddr[w*ADDR_W +: ADDR_W]][b*8 +: 8] =
                            wdata[w*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        // Entry 0 is architecturally constant.
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_s) begin
            for (int e = 0; e < c_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            assign w_ra = raddr[i*ADDR_W +: ADDR_W];

            regfile_rd_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NUM_WR (NUM_WR),
                .BYPASS (BYPASS),
                .DEPTH  (c_DEPTH)
            ) u_rd_port (
                .raddr_i  (w_ra),
                .mem_i    (mem_q),
                .byp_en_i (rst_s),
                .we_i     (we),
                .waddr_i  (waddr),
                .wdata_i  (wdata),
                .wbe_i    (wbe),
                .rdata_o  (rdata[i*DATA_W +: DATA_W])
            );

            // Busy is reported from stored state only; same-cycle set/clear
            // becomes visible after the edge.
            assign rbusy[i] = busy_q[w_ra];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Purpose : Directed, table-driven bench for regfile_mp. Two instances share
//           all inputs: one with forwarding, one without.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst_s;
    logic [1:0]  we;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic [11:0] raddr;
    logic        rsv_en;
    logic [5:0]  rsv_addr;
    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rbusy_b, rbusy_n;

    int passed = 0;
    int total  = 0;

    regfile_mp #(.BYPASS(1)) u_dut_byp (
        .clk(clk), .rst_s(rst_s), .we(we), .waddr(waddr), .wdata(wdata),
        .wbe(wbe), .raddr(raddr), .rdata(rdata_b), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rbusy(rbusy_b)
    );

    regfile_mp #(.BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst_s(rst_s), .we(we), .waddr(waddr), .wdata(wdata),
        .wbe(wbe), .raddr(raddr), .rdata(rdata_n), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rbusy(rbusy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [5:0]  wa0; logic [31:0] wd0; logic [3:0] wb0;
        logic [5:0]  wa1; logic [31:0] wd1; logic [3:0] wb1;
        logic        rsv; logic [5:0]  rsa;
        logic [5:0]  ra0; logic [5:0]  ra1;
        logic [31:0] e_rd0, e_rd1;   // forwarding instance, pre-edge
        logic [31:0] e_nb0, e_nb1;   // non-forwarding instance, pre-edge
        logic        e_bz0, e_bz1;   // stored busy, pre-edge
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [1:0] we_v,
        input logic [5:0] wa0, input logic [31:0] wd0, input logic [3:0] wb0,
        input logic [5:0] wa1, input logic [31:0] wd1, input logic [3:0] wb1,
        input logic rsv, input logic [5:0] rsa,
        input logic [5:0] ra0, input logic [5:0] ra1,
        input logic [31:0] rd0, input logic [31:0] rd1,
        input logic [31:0] nb0, input logic [31:0] nb1,
        input logic bz0, input logic bz1);
        vec_t v;
        v.we = we_v; v.wa0 = wa0; v.wd0 = wd0; v.wb0 = wb0;
        v.wa1 = wa1; v.wd1 = wd1; v.wb1 = wb1; v.rsv = rsv; v.rsa = rsa;
        v.ra0 = ra0; v.ra1 = ra1; v.e_rd0 = rd0; v.e_rd1 = rd1;
        v.e_nb0 = nb0; v.e_nb1 = nb1; v.e_bz0 = bz0; v.e_bz1 = bz1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        we       = v.we;
        waddr    = {v.wa1, v.wa0};
        wdata    = {v.wd1, v.wd0};
        wbe      = {v.wb1, v.wb0};
        rsv_en   = v.rsv;
        rsv_addr = v.rsa;
        raddr    = {v.ra1, v.ra0};
    endtask

    task automatic idle(input logic [5:0] ra0, input logic [5:0] ra1);
        we = '0; waddr = '0; wdata = '0; wbe = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        raddr = {ra1, ra0};
    endtask

    task automatic chk_all(input string tag, input logic [31:0] rd0, input logic [31:0] rd1,
                           input logic [31:0] nb0, input logic [31:0] nb1,
                           input logic bz0, input logic bz1);
        chk({tag, " byp_rd0"}, rdata_b[31:0],  rd0);
        chk({tag, " byp_rd1"}, rdata_b[63:32], rd1);
        chk({tag, " nob_rd0"}, rdata_n[31:0],  nb0);
        chk({tag, " nob_rd1"}, rdata_n[63:32], nb1);
        chk({tag, " byp_bz0"}, {31'd0, rbusy_b[0]}, {31'd0, bz0});
        chk({tag, " byp_bz1"}, {31'd0, rbusy_b[1]}, {31'd0, bz1});
        chk({tag, " nob_bz0"}, {31'd0, rbusy_n[0]}, {31'd0, bz0});
        chk({tag, " nob_bz1"}, {31'd0, rbusy_n[1]}, {31'd0, bz1});
    endtask

    initial begin
        //              we    wa0 wd0           wb0   wa1 wd1           wb1   rsv  rsa  ra0 ra1  rd0           rd1           nb0           nb1           bz0  bz1
        vecs[0]  = mk(2'b01, 2, 32'h11223344, 4'hF, 0, 32'h0,        4'h0, 0, 0,  2,  3, 32'h11223344, 32'h0,        32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(2'b01, 2, 32'hAABBCCDD, 4'h5, 0, 32'h0,        4'h0, 0, 0,  2,  0, 32'h11BB33DD, 32'h0,        32'h11223344, 32'h0,        0, 0);
        vecs[2]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  2,  0, 32'h11BB33DD, 32'h0,        32'h11BB33DD, 32'h0,        0, 0);
        vecs[3]  = mk(2'b11, 5, 32'h00000001, 4'hF, 5, 32'hFFFF0000, 4'hC, 0, 0,  5,  2, 32'hFFFF0001, 32'h11BB33DD, 32'h0,        32'h11BB33DD, 0, 0);
        vecs[4]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  5,  5, 32'hFFFF0001, 32'hFFFF0001, 32'hFFFF0001, 32'hFFFF0001, 0, 0);
        vecs[5]  = mk(2'b10, 0, 32'h0,        4'h0, 7, 32'h00000010, 4'hF, 0, 0,  7,  7, 32'h10,        32'h10,        32'h0,        32'h0,        0, 0);
        vecs[6]  = mk(2'b01, 7, 32'h00000003, 4'hF, 0, 32'h0,        4'h0, 0, 0,  7,  5, 32'h3,         32'hFFFF0001, 32'h10,        32'hFFFF0001, 0, 0);
        vecs[7]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  7,  7, 32'h3,         32'h3,         32'h3,         32'h3,         0, 0);
        vecs[8]  = mk(2'b01, 0, 32'hDEADBEEF, 4'hF, 0, 32'h0,        4'h0, 1, 0,  0,  0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        vecs[9]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  0,  7, 32'h0,         32'h3,         32'h0,         32'h3,         0, 0);
        vecs[10] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 1, 4,  4,  4, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        vecs[11] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  4,  0, 32'h0,         32'h0,         32'h0,         32'h0,         1, 0);
        vecs[12] = mk(2'b01, 4, 32'h00000044, 4'h1, 0, 32'h0,        4'h0, 0, 0,  4,  4, 32'h44,        32'h44,        32'h0,         32'h0,         1, 1);
        vecs[13] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  4,  0, 32'h44,        32'h0,         32'h44,        32'h0,         0, 0);
        vecs[14] = mk(2'b10, 0, 32'h0,        4'h0, 4, 32'hA5000000, 4'h8, 1, 4,  4,  2, 32'hA5000044, 32'h11BB33DD, 32'h44,        32'h11BB33DD, 0, 0);
        vecs[15] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  4,  4, 32'hA5000044, 32'hA5000044, 32'hA5000044, 32'hA5000044, 1, 1);
        vecs[16] = mk(2'b11, 63, 32'h12345678, 4'hF, 1, 32'hCAFEF00D, 4'h3, 0, 0, 63, 1, 32'h12345678, 32'h0000F00D, 32'h0,         32'h0,         0, 0);
        vecs[17] = mk(2'b00, 63, 32'hFFFFFFFF, 4'hF, 1, 32'hFFFFFFFF, 4'hF, 0, 0, 63, 1, 32'h12345678, 32'h0000F00D, 32'h12345678, 32'h0000F00D, 0, 0);
        vecs[18] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 1, 63, 63, 4, 32'h12345678, 32'hA5000044, 32'h12345678, 32'hA5000044, 0, 1);
        vecs[19] = mk(2'b00, 63, 32'hFFFFFFFF, 4'hF, 0, 32'h0,       4'h0, 0, 0, 63, 1, 32'h12345678, 32'h0000F00D, 32'h12345678, 32'h0000F00D, 1, 0);
        vecs[20] = mk(2'b01, 63, 32'hFFFFFFFF, 4'h0, 0, 32'h0,       4'h0, 0, 0, 63, 63, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1, 1);
        vecs[21] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0, 63, 4, 32'h12345678, 32'hA5000044, 32'h12345678, 32'hA5000044, 0, 1);
        vecs[22] = mk(2'b11, 2, 32'h00000000, 4'h3, 2, 32'hFFFFFFFF, 4'h0, 0, 0,  2, 3, 32'h11BB0000, 32'h0,         32'h11BB33DD, 32'h0,         0, 0);
        vecs[23] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0, 0,  2, 5, 32'h11BB0000, 32'hFFFF0001, 32'h11BB0000, 32'hFFFF0001, 0, 0);

        // Initial reset, then check the cleared state.
        rst_s = 1'b0;
        idle(0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_s = 1'b1;
        idle(5, 63);
        #2;
        chk_all("reset_state", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk_all($sformatf("v%0d", i), vecs[i].e_rd0, vecs[i].e_rd1,
                    vecs[i].e_nb0, vecs[i].e_nb1, vecs[i].e_bz0, vecs[i].e_bz1);
        end

        // Reset with concurrent write/reserve: reset wins, no forwarding.
        @(negedge clk);
        idle(1, 2);
        we = 2'b11; waddr = {6'd2, 6'd1}; wdata = {32'h1, 32'h1}; wbe = 8'hFF;
        @(negedge clk);
        idle(1, 3);
        we = 2'b01; waddr = {6'd0, 6'd3}; wdata = {32'h0, 32'h1}; wbe = 8'h0F;
        rsv_en = 1'b1; rsv_addr = 6'd3;
        @(negedge clk);
        idle(1, 3);
        #2;
        chk_all("pre_rst", 32'h1, 32'h1, 32'h1, 32'h1, 1'b0, 1'b1);
        @(negedge clk);
        rst_s = 1'b0;
        idle(1, 2);
        we = 2'b01; waddr = {6'd0, 6'd1}; wdata = {32'h0, 32'h000000FF}; wbe = 8'h0F;
        rsv_en = 1'b1; rsv_addr = 6'd2;
        #2;
        chk_all("in_rst", 32'h1, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        rst_s = 1'b1;
        idle(1, 2);
        #2;
        chk_all("post_rst_a", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(3, 7);
        #2;
        chk_all("post_rst_b", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
